// File: rtl/demux1x3_stream.sv
// ----------------------------------------------------------------------------
// demux1x3_stream: steers each 64-bit input word to one of three registered
// output slots by its 2-bit destination; destination 2'b11 is dropped and
// counted. Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module demux1x3_stream #(
  parameter int DW   = 64,
  parameter int CNTW = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [DW-1:0]   in_data,
  input  logic [1:0]      in_sel,
  output logic            out0_valid,
  input  logic            out0_ready,
  output logic [DW-1:0]   out0_data,
  output logic            out1_valid,
  input  logic            out1_ready,
  output logic [DW-1:0]   out1_data,
  output logic            out2_valid,
  input  logic            out2_ready,
  output logic [DW-1:0]   out2_data,
  output logic            err_sticky,
  input  logic            err_clr,
  output logic [CNTW-1:0] drop_cnt
);

  localparam logic [1:0] c_SEL_DROP = 2'b11;

  logic [2:0]          vld_q;
  logic [2:0]          vld_d;
  logic [2:0][DW-1:0]  data_q;
  logic [2:0][DW-1:0]  data_d;
  logic                err_q;
  logic                err_d;
  logic [CNTW-1:0]     cnt_q;
  logic [CNTW-1:0]     cnt_d;

  logic [2:0] out_rdy;
  logic [2:0] slot_free;
  logic       accept;
  logic       drop;

  assign out_rdy = {out2_ready, out1_ready, out0_ready};

  // A slot can take a new word when empty or when its current word leaves
  // this very cycle, which keeps a streaming port at one word per cycle.
  assign slot_free = ~vld_q | out_rdy;

  always_comb begin
    in_ready = 1'b1;
    case (in_sel)
      2'd0:    in_ready = slot_free[0];
      2'd1:    in_ready = slot_free[1];
      2'd2:    in_ready = slot_free[2];
      default: in_ready = 1'b1;
    endcase
  end

  assign accept = in_valid && in_ready;
  assign drop   = accept && (in_sel == c_SEL_DROP);

  always_comb begin
    vld_d  = vld_q;
    data_d = data_q;
    for (int i = 0; i < 3; i++) begin
      if (accept && (in_sel == 2'(i))) begin
        vld_d[i]  = 1'b1;
        data_d[i] = in_data;
      end else if (vld_q[i] && out_rdy[i]) begin
        vld_d[i] = 1'b0;
      end
    end
  end

  // A drop in the same cycle as err_clr wins: it restarts the count at one.
  always_comb begin
    err_d = err_q;
    cnt_d = cnt_q;
    if (drop) begin
      err_d = 1'b1;
      if (err_clr) begin
        cnt_d = CNTW'(1);
      end else if (cnt_q != {CNTW{1'b1}}) begin
        cnt_d = cnt_q + CNTW'(1);
      end
    end else if (err_clr) begin
      err_d = 1'b0;
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q  <= '0;
      data_q <= '0;
      err_q  <= 1'b0;
      cnt_q  <= '0;
    end else begin
      vld_q  <= vld_d;
      data_q <= data_d;
      err_q  <= err_d;
      cnt_q  <= cnt_d;
    end
  end

  assign out0_valid = vld_q[0];
  assign out1_valid = vld_q[1];
  assign out2_valid = vld_q[2];
  assign out0_data  = data_q[0];
  assign out1_data  = data_q[1];
  assign out2_data  = data_q[2];
  assign err_sticky = err_q;
  assign drop_cnt   = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_demux1x3_stream.sv
// ----------------------------------------------------------------------------
// tb_demux1x3_stream: directed-vector self-checking bench for demux1x3_stream.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_demux1x3_stream;

  localparam int DW   = 64;
  localparam int CNTW = 16;

  logic            clk;
  logic            rst_n;
  logic            in_valid;
  logic            in_ready;
  logic [DW-1:0]   in_data;
  logic [1:0]      in_sel;
  logic            out0_valid, out1_valid, out2_valid;
  logic            out0_ready, out1_ready, out2_ready;
  logic [DW-1:0]   out0_data, out1_data, out2_data;
  logic            err_sticky;
  logic            err_clr;
  logic [CNTW-1:0] drop_cnt;

  int n_cmp;
  int n_err;

  demux1x3_stream #(.DW(DW), .CNTW(CNTW)) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_sel     (in_sel),
    .out0_valid (out0_valid),
    .out0_ready (out0_ready),
    .out0_data  (out0_data),
    .out1_valid (out1_valid),
    .out1_ready (out1_ready),
    .out1_data  (out1_data),
    .out2_valid (out2_valid),
    .out2_ready (out2_ready),
    .out2_data  (out2_data),
    .err_sticky (err_sticky),
    .err_clr    (err_clr),
    .drop_cnt   (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_cmp      = 0;
    n_err      = 0;
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    in_data    = '0;
    in_sel     = 2'b00;
    out0_ready = 1'b0;
    out1_ready = 1'b0;
    out2_ready = 1'b0;
    err_clr    = 1'b0;

    // Reset state
    #2;
    chk("rst_v0", 64'(out0_valid), 64'd0);
    chk("rst_v1", 64'(out1_valid), 64'd0);
    chk("rst_v2", 64'(out2_valid), 64'd0);
    chk("rst_d0", out0_data, 64'd0);
    chk("rst_err", 64'(err_sticky), 64'd0);
    chk("rst_cnt", 64'(drop_cnt), 64'd0);
    chk("rst_rdy", 64'(in_ready), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Single word to port 0
    in_valid   = 1'b1;
    in_sel     = 2'b00;
    in_data    = 64'h1111_2222_3333_4444;
    out0_ready = 1'b1;
    #1;
    chk("p0_rdy", 64'(in_ready), 64'd1);
    step();
    in_valid = 1'b0;
    chk("p0_v0", 64'(out0_valid), 64'd1);
    chk("p0_d0", out0_data, 64'h1111_2222_3333_4444);
    chk("p0_v1", 64'(out1_valid), 64'd0);
    chk("p0_v2", 64'(out2_valid), 64'd0);
    step();
    chk("p0_drain", 64'(out0_valid), 64'd0);

    // Back-to-back stream to port 1
    out1_ready = 1'b1;
    in_sel     = 2'b01;
    in_valid   = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      in_data = 64'(k);
      #1;
      chk("b2b_rdy", 64'(in_ready), 64'd1);
      step();
      chk("b2b_v1", 64'(out1_valid), 64'd1);
      chk("b2b_d1", out1_data, 64'(k));
    end
    in_valid = 1'b0;
    step();
    chk("b2b_end", 64'(out1_valid), 64'd0);

    // Stalled port 2, then pass-through replacement
    out2_ready = 1'b0;
    in_sel     = 2'b10;
    in_data    = 64'hAAAA_0000_0000_0001;
    in_valid   = 1'b1;
    step();
    in_data = 64'hBBBB_0000_0000_0002;
    #1;
    chk("stl_v2", 64'(out2_valid), 64'd1);
    chk("stl_rdy", 64'(in_ready), 64'd0);
    step();
    chk("stl_hold", out2_data, 64'hAAAA_0000_0000_0001);
    out2_ready = 1'b1;
    #1;
    chk("stl_rdy1", 64'(in_ready), 64'd1);
    step();
    in_valid = 1'b0;
    chk("stl_v2b", 64'(out2_valid), 64'd1);
    chk("stl_new", out2_data, 64'hBBBB_0000_0000_0002);
    step();
    chk("stl_drain", 64'(out2_valid), 64'd0);

    // Head-of-line blocking behind stalled slot 0
    out0_ready = 1'b0;
    in_sel     = 2'b00;
    in_data    = 64'hC0C0_C0C0_C0C0_C0C0;
    in_valid   = 1'b1;
    step();
    in_data = 64'hE0E0_E0E0_E0E0_E0E0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("hol_rdy", 64'(in_ready), 64'd0);
      step();
      chk("hol_v1", 64'(out1_valid), 64'd0);
      chk("hol_d0", out0_data, 64'hC0C0_C0C0_C0C0_C0C0);
    end
    out0_ready = 1'b1;
    step();
    chk("hol_d0new", out0_data, 64'hE0E0_E0E0_E0E0_E0E0);
    in_sel  = 2'b01;
    in_data = 64'hD0D0_D0D0_D0D0_D0D0;
    step();
    in_valid = 1'b0;
    chk("hol_v1b", 64'(out1_valid), 64'd1);
    chk("hol_d1", out1_data, 64'hD0D0_D0D0_D0D0_D0D0);
    step();

    // Illegal destination drops and err_clr interaction
    in_sel   = 2'b11;
    in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      in_data = 64'hDEAD_0000_0000_0000 | 64'(k);
      #1;
      chk("drp_rdy", 64'(in_ready), 64'd1);
      step();
      chk("drp_vld", 64'({out2_valid, out1_valid, out0_valid}), 64'd0);
    end
    in_valid = 1'b0;
    #1;
    chk("drp_cnt3", 64'(drop_cnt), 64'd3);
    chk("drp_err", 64'(err_sticky), 64'd1);
    in_valid = 1'b1;
    err_clr  = 1'b1;
    step();
    in_valid = 1'b0;
    chk("clr_drop_cnt", 64'(drop_cnt), 64'd1);
    chk("clr_drop_err", 64'(err_sticky), 64'd1);
    step();
    err_clr = 1'b0;
    chk("clr_cnt", 64'(drop_cnt), 64'd0);
    chk("clr_err", 64'(err_sticky), 64'd0);

    // Saturation of the drop counter
    in_valid = 1'b1;
    repeat (65535) step();
    chk("sat_max", 64'(drop_cnt), 64'h0000_0000_0000_FFFF);
    step();
    in_valid = 1'b0;
    chk("sat_hold", 64'(drop_cnt), 64'h0000_0000_0000_FFFF);

    // Fill all slots, then asynchronous reset between clock edges
    out0_ready = 1'b0;
    out1_ready = 1'b0;
    out2_ready = 1'b0;
    in_valid   = 1'b1;
    for (int k = 0; k < 3; k++) begin
      in_sel  = 2'(k);
      in_data = 64'h5000 + 64'(k);
      step();
    end
    in_valid = 1'b0;
    chk("full_vld", 64'({out2_valid, out1_valid, out0_valid}), 64'd7);
    chk("full_d2", out2_data, 64'h5002);
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_vld", 64'({out2_valid, out1_valid, out0_valid}), 64'd0);
    chk("arst_cnt", 64'(drop_cnt), 64'd0);
    chk("arst_err", 64'(err_sticky), 64'd0);
    chk("arst_d1", out1_data, 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/demux1x3_stream.md
Name: demux1x3_stream

Overview:
- 64-bit, one-input to three-output stream distributor. It is the inverse of the team's 3:1 64-bit select mux: one producer steers each word to one of three consumers.
- A 2-bit destination travels with each word. Each destination has a one-entry registered output slot with valid/ready handshake.
- Destination 2'b11 is illegal: the word is accepted, discarded and counted, mirroring the zero output of the 3:1 mux for that code.
- Sits between a result producer and three downstream consumers, e.g. the writeback, forwarding and store paths.

Parameters:
- DW, 64, data width of input and every output.
- CNTW, 16, width of the saturating drop counter.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  input word valid.
- in_ready  output  1  input can be accepted this cycle.
- in_data  input  DW  input word.
- in_sel  input  2  destination: 00 -> port 0, 01 -> port 1, 10 -> port 2, 11 -> illegal.
- out0_valid / out1_valid / out2_valid  output  1 each  slot holds a word.
- out0_ready / out1_ready / out2_ready  input  1 each  consumer takes the word.
- out0_data / out1_data / out2_data  output  DW each  slot contents.
- err_sticky  output  1  set by any illegal-destination drop.
- err_clr  input  1  synchronous clear of err_sticky and drop_cnt.
- drop_cnt  output  CNTW  number of dropped words, saturating.

Behaviour:
- Reset (rst_n low, asynchronous):
  - all outN_valid = 0, all outN_data = 0.
  - err_sticky = 0, drop_cnt = 0.
  - in_ready evaluates per its combinational equation; with empty slots it is 1.
- Accept: in_valid && in_ready at a rising edge.
- in_ready (combinational, depends on in_sel and slot state, no dependency on in_valid):
  - sel = i (0..2): in_ready = !outi_valid || outi_ready. Pass-through ready gives full throughput.
  - sel = 11: in_ready = 1.
- Slot i next state:
  - accept with sel = i: outi_valid <= 1, outi_data <= in_data. This applies even when the same cycle drains the old word; the old word leaves and the new one replaces it, and valid stays 1.
  - else, outi_valid && outi_ready: outi_valid <= 0. outi_data holds its value; it is don't-care.
  - else: hold.
- Latency: an accepted word appears on outN one cycle after acceptance. Sustained rate is 1 word/cycle per port.
- Output stability: while outi_valid = 1 and outi_ready = 0, outi_data and outi_valid are stable.
- Ordering:
  - preserved per port.
  - no ordering guarantee across ports.
  - one word accepted per cycle, so at most one slot loads per cycle; other slots may drain in the same cycle.
- Blocking: a stalled target blocks the input even when other slots are empty. There is no reordering or bypass.
- Illegal drop: accept with sel = 11 loads no slot.
  - err_sticky <= 1.
  - drop_cnt <= drop_cnt + 1, saturating at all-ones (no wrap).
- err_clr:
  - clears err_sticky and drop_cnt.
  - if a drop occurs in the same cycle, the result is err_sticky = 1, drop_cnt = 1 (the drop wins).
- Reset mid-transfer: all pending slot words are lost, and the valids drop immediately (asynchronous). No partial state survives.
- Protocol rules:
  - in_valid must not depend on in_ready.
  - in_data and in_sel must be stable while in_valid && !in_ready.

Test Plan:
- Reset, then in_sel=00, in_data=64'h1111_2222_3333_4444 with out0_ready=1 -> in_ready=1; the next cycle out0_valid=1 with that data; out1_valid = out2_valid = 0.
- Back-to-back words 1,2,3,4 to sel=01 with out1_ready=1 -> out1 shows 1,2,3,4 on consecutive cycles, no bubbles, in_ready constantly 1.
- Fill slot 2 with out2_ready=0, then present a word to sel=10 -> in_ready=0 and out2_data unchanged. Raise out2_ready -> the same cycle accepts the new word, and the next cycle shows the new data with out2_valid still 1.
- Slot 0 stalled; present sel=01 while a sel=00 word waits -> head-of-line blocking confirmed: the sel=01 word is not accepted until slot 0 drains.
- Three words with sel=11 -> in_ready=1 each cycle, no outN_valid, drop_cnt=3, err_sticky=1. Then err_clr together with a fourth sel=11 word -> drop_cnt=1, err_sticky=1.
- Preload drop_cnt to 16'hFFFF via 65535 drops, then one more drop -> drop_cnt stays 16'hFFFF. Assert rst_n=0 mid-stream with all slots full -> all valids 0, drop_cnt 0 immediately without a clock edge.
